// File: rtl/image_pkg.sv
// Shared types and BMP constants for the image writer slice.
package image_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int BMP_HDR_SIZE = 54;
  localparam int BMP_DIB_SIZE = 40;
  localparam int BMP_BPP      = 24;
  localparam int HDR_WORDS    = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Memory byte order is B0,G0,R0,B1,G1,R1 from the low byte up.
  function automatic logic [47:0] pack_pair(rgb_t p0, rgb_t p1);
    return {p1.r, p1.g, p1.b, p0.r, p0.g, p0.b};
  endfunction

endpackage

// File: rtl/image_writer_if.sv
// Pixel stream in, frame-memory write port and status out.
interface image_writer_if #(
  parameter int ADDR_W = 21
);
  logic              VSYNC;
  logic              HSYNC;
  logic [7:0]        DATA_R0;
  logic [7:0]        DATA_G0;
  logic [7:0]        DATA_B0;
  logic [7:0]        DATA_R1;
  logic [7:0]        DATA_G1;
  logic [7:0]        DATA_B1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [47:0]       wr_data;
  logic              frame_done;
  logic              line_err;

  modport master (
    output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  wr_en, wr_addr, wr_data, frame_done, line_err
  );

  modport slave (
    input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output wr_en, wr_addr, wr_data, frame_done, line_err
  );
endinterface

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP header served as nine little-endian 48-bit words.
module bmp_header_rom
  import image_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic [3:0]  idx,
  output logic [47:0] word
);

  localparam logic [31:0] IMG_BYTES = 32'(WIDTH * HEIGHT * 3);

  // Fields listed from the last header byte down to byte 0, so byte k sits at bits 8k+7:8k.
  localparam logic [431:0] HDR = {
    32'd0,                          // colours important
    32'd0,                          // colours used
    32'd0,                          // y pixels per metre
    32'd0,                          // x pixels per metre
    IMG_BYTES,
    32'd0,                          // compression
    16'(BMP_BPP),
    16'd1,                          // planes
    32'(HEIGHT),
    32'(WIDTH),
    32'(BMP_DIB_SIZE),
    32'(BMP_HDR_SIZE),              // pixel data offset
    32'd0,                          // reserved
    32'(BMP_HDR_SIZE) + IMG_BYTES,  // file size
    16'h4D42                        // "BM"
  };

  always_comb begin
    word = '0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (idx == 4'(i)) word = HDR[48*i +: 48];
    end
  end

endmodule

// File: rtl/image_writer.sv
// Turns a two-pixel-per-cycle RGB stream into a bottom-up 24-bit BMP image in byte-addressed memory.
// All writes are registered: one word per cycle, visible the cycle after the header step or pixel capture.
module image_writer
  import image_pkg::*;
#(
  parameter int WIDTH    = 768,
  parameter int HEIGHT   = 512,
  parameter int ADDR_W   = 21,
  parameter int HDR_SIZE = 54
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  image_writer_if.slave bus
);

  localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0]     COL_LAST  = CW'(WIDTH - 2);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [3:0]        HDR_LAST  = 4'(HDR_WORDS - 1);
  localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(WIDTH * 3);
  localparam logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(HDR_SIZE);

  state_t            state, state_n;
  logic              vs_q, vs_rise;
  logic [3:0]        hdr_idx, hdr_n;
  logic [RW-1:0]     row, row_n;
  logic [CW-1:0]     col, col_n;
  logic              wen_q, wen_n;
  logic [ADDR_W-1:0] addr_q, addr_n, pix_addr;
  logic [47:0]       data_q, data_n, hdr_word;
  logic              done_q, done_n;
  logic              err_q, err_n;
  rgb_t              px0, px1;

  bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_rom (
    .idx  (hdr_idx),
    .word (hdr_word)
  );

  assign vs_rise  = bus.VSYNC & ~vs_q;
  assign px0      = '{r: bus.DATA_R0, g: bus.DATA_G0, b: bus.DATA_B0};
  assign px1      = '{r: bus.DATA_R1, g: bus.DATA_G1, b: bus.DATA_B1};
  // Image row 0 is the top of the picture but the last row stored in a bottom-up BMP.
  assign pix_addr = DATA_BASE + ADDR_W'(ROW_LAST - row) * ROW_BYTES
                  + ADDR_W'(col) * ADDR_W'(3);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    hdr_n   = hdr_idx;
    row_n   = row;
    col_n   = col;
    wen_n   = 1'b0;
    addr_n  = addr_q;
    data_n  = data_q;
    done_n  = done_q;
    err_n   = err_q;
    if (vs_rise) begin
      state_n = ST_HDR;
      hdr_n   = '0;
      row_n   = '0;
      col_n   = '0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_HDR: begin
          wen_n  = 1'b1;
          addr_n = ADDR_W'(hdr_idx) * ADDR_W'(6);
          data_n = hdr_word;
          if (bus.HSYNC) err_n = 1'b1;
          if (hdr_idx == HDR_LAST) state_n = ST_WAIT;
          else                     hdr_n   = hdr_idx + 4'd1;
        end
        ST_WAIT, ST_DATA: begin
          if (bus.HSYNC) begin
            wen_n  = 1'b1;
            addr_n = pix_addr;
            data_n = pack_pair(px0, px1);
            if (col == COL_LAST) begin
              col_n = '0;
              if (row == ROW_LAST) begin
                state_n = ST_DONE;
                done_n  = 1'b1;
              end else begin
                row_n   = row + RW'(1);
                state_n = ST_WAIT;
              end
            end else begin
              col_n   = col + CW'(2);
              state_n = ST_DATA;
            end
          end else if (state == ST_DATA) begin
            // A line cut short keeps its position and resumes on the next HSYNC.
            state_n = ST_WAIT;
            if (col != '0) err_n = 1'b1;
          end
        end
        ST_DONE: if (bus.HSYNC) err_n = 1'b1;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vs_q    <= 1'b0;
      hdr_idx <= '0;
      row     <= '0;
      col     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vs_q    <= bus.VSYNC;
      hdr_idx <= hdr_n;
      row     <= row_n;
      col     <= col_n;
      wen_q   <= wen_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign bus.wr_en      = wen_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign bus.frame_done = done_q;
  assign bus.line_err   = err_q;

endmodule

// File: tb/tb_image_writer.sv
// Bench: full-size instance pinned with literals, 8x4 instance checked every cycle against a frame-level model.
module tb_image_writer;

  localparam int SW = 8;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  image_writer_if #(.ADDR_W(21)) ifb ();
  image_writer_if #(.ADDR_W(21)) ifs ();

  image_writer #(.WIDTH(768), .HEIGHT(512), .ADDR_W(21), .HDR_SIZE(54)) u_big (
    .HCLK(clk), .HRESETn(rst_n), .bus(ifb)
  );
  image_writer #(.WIDTH(SW), .HEIGHT(SH), .ADDR_W(21), .HDR_SIZE(54)) u_small (
    .HCLK(clk), .HRESETn(rst_n), .bus(ifs)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- frame-level model of the 8x4 instance ----------------
  function automatic logic [47:0] m_hdr_word(int k);
    logic [7:0]  b [54];
    logic [47:0] w;
    int fsz, img;
    img = SW * SH * 3;
    fsz = 54 + img;
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h42;
    b[1] = 8'h4D;
    for (int j = 0; j < 4; j++) begin
      b[2 + j]  = 8'(fsz >> (8 * j));
      b[10 + j] = 8'(54 >> (8 * j));
      b[14 + j] = 8'(40 >> (8 * j));
      b[18 + j] = 8'(SW >> (8 * j));
      b[22 + j] = 8'(SH >> (8 * j));
      b[34 + j] = 8'(img >> (8 * j));
    end
    b[26] = 8'd1;
    b[28] = 8'd24;
    w = '0;
    for (int j = 0; j < 6; j++) w[8*j +: 8] = b[6*k + j];
    return w;
  endfunction

  function automatic int m_pix_addr(int n);
    int r, c;
    r = n / (SW / 2);
    c = 2 * (n % (SW / 2));
    return 54 + (SH - 1 - r) * SW * 3 + c * 3;
  endfunction

  int          m_phase, m_hcnt, m_n;
  bit          m_open, m_vs;
  bit          m_wen, m_done, m_err;
  int          m_addr;
  logic [47:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_hcnt = 0; m_n = 0; m_open = 0; m_vs = 0;
      m_wen = 0; m_done = 0; m_err = 0; m_addr = 0; m_data = '0;
    end else begin
      m_wen = 0;
      if (ifs.VSYNC && !m_vs) begin
        m_phase = 1; m_hcnt = 0; m_n = 0; m_open = 0; m_done = 0; m_err = 0;
      end else if (m_phase == 1) begin
        m_wen  = 1;
        m_addr = 6 * m_hcnt;
        m_data = m_hdr_word(m_hcnt);
        if (ifs.HSYNC) m_err = 1;
        m_hcnt++;
        if (m_hcnt == 9) m_phase = 2;
      end else if (m_phase == 2) begin
        if (ifs.HSYNC) begin
          m_wen  = 1;
          m_addr = m_pix_addr(m_n);
          m_data = {ifs.DATA_R1, ifs.DATA_G1, ifs.DATA_B1, ifs.DATA_R0, ifs.DATA_G0, ifs.DATA_B0};
          m_n++;
          m_open = (m_n % (SW / 2)) != 0;
          if (m_n == SW * SH / 2) begin
            m_phase = 3; m_done = 1; m_open = 0;
          end
        end else begin
          if (m_open) m_err = 1;
          m_open = 0;
        end
      end else if (m_phase == 3) begin
        if (ifs.HSYNC) m_err = 1;
      end
      m_vs = ifs.VSYNC;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_wr_en", 64'(ifs.wr_en), 64'(m_wen));
      chk("cyc_wr_addr", 64'(ifs.wr_addr), 64'(m_addr));
      chk("cyc_wr_data", 64'(ifs.wr_data), 64'(m_data));
      chk("cyc_frame_done", 64'(ifs.frame_done), 64'(m_done));
      chk("cyc_line_err", 64'(ifs.line_err), 64'(m_err));
    end
  end

  // Write log of the small instance, used for literal frame-level checks.
  int wcnt = 0;
  int aq[$];
  int pq[$];
  bit pdq[$];
  always @(negedge clk) begin
    if (ifs.wr_en) begin
      wcnt++;
      aq.push_back(int'(ifs.wr_addr));
      if (ifs.wr_addr >= 21'd54) begin
        pq.push_back(int'(ifs.wr_addr));
        pdq.push_back(ifs.frame_done);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pix();
    ifs.DATA_R0 = 8'($urandom); ifs.DATA_G0 = 8'($urandom); ifs.DATA_B0 = 8'($urandom);
    ifs.DATA_R1 = 8'($urandom); ifs.DATA_G1 = 8'($urandom); ifs.DATA_B1 = 8'($urandom);
  endtask

  task automatic pairs(input int n);
    for (int i = 0; i < n; i++) begin
      ifs.HSYNC = 1'b1;
      rand_pix();
      cyc();
    end
    ifs.HSYNC = 1'b0;
  endtask

  task automatic start_frame();
    ifs.VSYNC = 1'b1;
    repeat (10) cyc();
    ifs.VSYNC = 1'b0;
    chk("hdr_done_clr", 64'(ifs.frame_done), 64'd0);
    chk("hdr_err_clr", 64'(ifs.line_err), 64'd0);
  endtask

  task automatic run_frame(input int gap);
    start_frame();
    for (int r = 0; r < SH; r++) begin
      repeat ((gap < 0) ? $urandom_range(1, 4) : gap) cyc();
      pairs(SW / 2);
    end
    repeat (3) cyc();
  endtask

  task automatic check_frame(input string tag, input bit err_exp);
    chk({tag, "_nwrites"}, 64'(pq.size()), 64'd16);
    chk({tag, "_row0"}, 64'(pq.size() > 0 ? pq[0] : -1), 64'd126);
    chk({tag, "_row3"}, 64'(pq.size() > 12 ? pq[12] : -1), 64'd54);
    chk({tag, "_last"}, 64'(pq.size() > 15 ? pq[15] : -1), 64'd72);
    chk({tag, "_done15"}, 64'(pq.size() > 15 ? pdq[15] : 1'b0), 64'd1);
    chk({tag, "_done14"}, 64'(pq.size() > 14 ? pdq[14] : 1'b1), 64'd0);
    chk({tag, "_done_lvl"}, 64'(ifs.frame_done), 64'd1);
    chk({tag, "_err"}, 64'(ifs.line_err), 64'(err_exp));
  endtask

  int          nh;
  int          ha [9];
  logic [47:0] hd [9];

  initial begin
    rst_n = 1'b0;
    ifb.VSYNC = 0; ifb.HSYNC = 0;
    ifb.DATA_R0 = 0; ifb.DATA_G0 = 0; ifb.DATA_B0 = 0;
    ifb.DATA_R1 = 0; ifb.DATA_G1 = 0; ifb.DATA_B1 = 0;
    ifs.VSYNC = 0; ifs.HSYNC = 0;
    ifs.DATA_R0 = 0; ifs.DATA_G0 = 0; ifs.DATA_B0 = 0;
    ifs.DATA_R1 = 0; ifs.DATA_G1 = 0; ifs.DATA_B1 = 0;
    repeat (3) cyc();
    cmp_en = 1'b1;

    chk("model_hdr0", m_hdr_word(0), 48'h0000_0096_4D42);
    chk("model_hdr3", m_hdr_word(3), 48'h0004_0000_0008);
    chk("model_pix0", 64'(m_pix_addr(0)), 64'd126);
    chk("model_pix12", 64'(m_pix_addr(12)), 64'd54);

    chk("rst_wr_en", 64'(ifb.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(ifb.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(ifb.wr_data), 64'd0);
    chk("rst_frame_done", 64'(ifb.frame_done), 64'd0);
    chk("rst_line_err", 64'(ifb.line_err), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Full-size header and first pair.
    ifb.VSYNC = 1'b1;
    nh = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (i == 3) ifb.VSYNC = 1'b0;
      if (ifb.wr_en) begin
        if (nh < 9) begin
          ha[nh] = int'(ifb.wr_addr);
          hd[nh] = ifb.wr_data;
        end
        nh++;
      end
    end
    chk("big_hdr_count", 64'(nh), 64'd9);
    for (int k = 0; k < 9; k++) chk("big_hdr_addr", 64'(ha[k]), 64'(6 * k));
    chk("big_hdr_w0", hd[0], 48'h0012_0036_4D42);
    chk("big_hdr_w1", hd[1], 48'h0036_0000_0000);
    chk("big_hdr_w2", hd[2], 48'h0000_0028_0000);
    chk("big_hdr_w3", hd[3], 48'h0200_0000_0300);
    chk("big_hdr_w4", hd[4], 48'h0018_0001_0000);
    chk("big_hdr_w6", hd[6], 48'h0000_0000_0012);
    chk("big_hdr_w8", hd[8], 48'h0);
    chk("big_idle_wr_en", 64'(ifb.wr_en), 64'd0);
    ifb.HSYNC = 1'b1;
    ifb.DATA_R0 = 8'd10; ifb.DATA_G0 = 8'd20; ifb.DATA_B0 = 8'd30;
    ifb.DATA_R1 = 8'd40; ifb.DATA_G1 = 8'd50; ifb.DATA_B1 = 8'd60;
    cyc();
    ifb.HSYNC = 1'b0;
    chk("big_pix_wr_en", 64'(ifb.wr_en), 64'd1);
    chk("big_pix_addr", 64'(ifb.wr_addr), 64'd1177398);
    chk("big_pix_data", 64'(ifb.wr_data), 64'h28323C0A141E);
    cyc();

    // Clean 8x4 frame with a fixed gap, then a second frame started while done.
    pq.delete(); pdq.delete();
    run_frame(5);
    check_frame("f1", 1'b0);
    pq.delete(); pdq.delete();
    run_frame(-1);
    check_frame("f2", 1'b0);

    // Line broken after two pairs resumes at column 4 of the same row.
    pq.delete(); pdq.delete();
    start_frame();
    repeat (2) cyc();
    pairs(2);
    repeat (3) cyc();
    chk("brk_err", 64'(ifs.line_err), 64'd1);
    pairs(2);
    chk("brk_resume", 64'(pq.size() > 2 ? pq[2] : -1), 64'd138);
    for (int r = 1; r < SH; r++) begin
      repeat (2) cyc();
      pairs(SW / 2);
    end
    repeat (3) cyc();
    check_frame("f3", 1'b1);

    // Reset in the middle of a line.
    start_frame();
    ifs.HSYNC = 1'b1;
    rand_pix();
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(ifs.wr_en), 64'd0);
    chk("mid_rst_addr", 64'(ifs.wr_addr), 64'd0);
    chk("mid_rst_data", 64'(ifs.wr_data), 64'd0);
    chk("mid_rst_err", 64'(ifs.line_err), 64'd0);
    ifs.HSYNC = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    wcnt = 0;
    pairs(6);
    repeat (2) cyc();
    chk("post_rst_nowrite", 64'(wcnt), 64'd0);
    aq.delete();
    ifs.VSYNC = 1'b1;
    repeat (12) cyc();
    ifs.VSYNC = 1'b0;
    chk("restart_count", 64'(aq.size()), 64'd9);
    chk("restart_addr0", 64'(aq.size() > 0 ? aq[0] : -1), 64'd0);

    // Randomized frames, including HSYNC during header/done and a mid-frame VSYNC edge.
    for (int f = 0; f < 4; f++) begin
      ifs.VSYNC = 1'b1;
      for (int t = 0; t < 90; t++) begin
        if (t == 10) ifs.VSYNC = 1'b0;
        if (f == 2 && t == 50) ifs.VSYNC = 1'b1;
        if (f == 2 && t == 60) ifs.VSYNC = 1'b0;
        if (t < 10) ifs.HSYNC = ($urandom_range(0, 7) == 0);
        else        ifs.HSYNC = ($urandom_range(0, 3) != 0);
        rand_pix();
        cyc();
      end
      ifs.HSYNC = 1'b0;
      repeat (3) cyc();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
